dump_ctrl: RTL and testbench
============================

# dump_ctrl

Readout stage that sits directly downstream of the capture controller and its sample RAM. Once a capture has finished (`capture_done` high), a `dump` command from cmd_cfg makes the block read every RAM entry, oldest first, starting at the capture controller's final write address and wrapping at `ENTRIES`. Each byte goes to the UART transmitter through a `trmt`/`tx_done` handshake. At the end the block pulses `dump_done`, and cmd_cfg uses that pulse to clear `capture_done` and re-arm capture.

## Interface
- `ENTRIES`, 384: number of sample RAM entries; need not be a power of two.
- `LOG2`, 9: address width; must satisfy 2^LOG2 ≥ ENTRIES.

Ports:
- `clk`  in  1  system clock; the only clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `dump`  in  1  one-cycle command pulse from cmd_cfg.
- `capture_done`  in  1  capture-complete flag from cmd_cfg.
- `waddr_cap`  in  LOG2  capture controller `waddr`; the oldest entry once capture is done.
- `rdata`  in  8  RAM read data, valid the cycle after `re`.
- `tx_done`  in  1  one-cycle pulse from the UART when the current byte has been sent.
- `raddr`  out  LOG2  RAM read address.
- `re`  out  1  RAM read enable.
- `tx_data`  out  8  byte presented to the UART.
- `trmt`  out  1  one-cycle transmit strobe.
- `dump_busy`  out  1  high from command acceptance until `dump_done`.
- `dump_done`  out  1  one-cycle completion pulse.

## Operation
- States: IDLE, RD, LATCH, WAIT_TX.
- IDLE
  - `dump` with `capture_done` = 1: load `raddr` ← `waddr_cap`, clear `cnt`, set `dump_busy`, go to RD.
  - `dump` with `capture_done` = 0: ignored; stay in IDLE with no outputs.
- RD: `re` = 1 for exactly one cycle, then go to LATCH.
- LATCH: register `rdata` into `tx_data`, pulse `trmt` (registered), go to WAIT_TX.
- WAIT_TX, on `tx_done`:
  - if `cnt` == ENTRIES-1: pulse `dump_done`, clear `dump_busy`, go to IDLE.
  - else: increment `cnt`, advance `raddr`, go to RD.
- Address advance: `raddr` == ENTRIES-1 wraps to 0; otherwise +1. Never reaches values ≥ ENTRIES.
- `cnt` is LOG2 bits wide and counts 0..ENTRIES-1. Exactly ENTRIES bytes are sent per dump.
- Stray events:
  - `dump` while busy is ignored; the running sequence is unchanged.
  - `tx_done` outside WAIT_TX is ignored.
  - `capture_done` dropping mid-dump does not abort the dump.
- `tx_data` holds its value between `trmt` strobes.

## Timing
- Reset values: state IDLE, `raddr` = 0, `cnt` = 0, `re` = 0, `tx_data` = 0, `trmt` = 0, `dump_busy` = 0, `dump_done` = 0.
- Reset mid-dump returns every output to these values immediately. No resume; the next `dump` starts from the current `waddr_cap`.
- First byte: `dump` sampled at edge k → `re` high after edge k+1 → `trmt` high for one cycle after edge k+3, with `tx_data` valid in the same cycle.
- Subsequent bytes: `tx_done` sampled at edge m → next `trmt` after edge m+3.
- `dump_done` is high for one cycle after the edge that samples the final `tx_done`. `dump_busy` falls in that same cycle.
- A new `dump` is accepted in the cycle after `dump_done`.
- The RAM is synchronous-read with one cycle of latency. No combinational path from `rdata` to any output.

## Structure
- Shared analyzer package holds the `dump_state_t` enum (IDLE, RD, LATCH, WAIT_TX).
- `ENTRIES` and `LOG2` defaults come from the same package constants the capture controller uses.
- One sub-module: `circ_ptr`. It is a LOG2-bit load/increment pointer that wraps at ENTRIES-1.
  - The capture controller can reuse it for `waddr`.
  - dump_ctrl instantiates it for `raddr`.

## Test plan
Bench uses a behavioral synchronous RAM with `mem[i]` = i + 8'h10. The UART model returns `tx_done` 4 cycles after `trmt` unless stated otherwise.

1. ENTRIES=8, `waddr_cap`=0, `capture_done`=1, pulse `dump` → `tx_data` sequence 10,11,…,17 on `trmt`; one `dump_done` after the 8th `tx_done`; `trmt` exactly 3 edges after `dump`.
2. ENTRIES=8, `waddr_cap`=5 → `raddr` 5,6,7,0,1,2,3,4; bytes 15,16,17,10,…,14.
3. ENTRIES=384, `waddr_cap`=383 → `raddr` 383 then 0; 384 `trmt` pulses total; `raddr` never ≥ 384.
4. `dump` with `capture_done`=0 → no `re`, no `trmt`, `dump_busy` stays 0.
5. Extra `dump` pulses and stray `tx_done` pulses injected mid-dump (during RD and LATCH) → byte sequence and count unchanged.
6. Reset asserted after the 3rd byte → all outputs at reset values; a new `dump` with `waddr_cap`=2 yields 12,13,… from the start.

Source files
------------

// File: rtl/dump_ctrl_pkg.sv
// Shared analyzer constants and readout FSM state encoding.
// Sample RAM depth and address width are common to capture and dump.
package dump_ctrl_pkg;

  localparam int CAP_ENTRIES = 384;
  localparam int CAP_LOG2    = 9;

  typedef enum logic [1:0] {
    IDLE,
    RD,
    LATCH,
    WAIT_TX
  } dump_state_t;

endpackage

// File: rtl/dump_ctrl_if.sv
// Readout bundle: cmd_cfg command, capture address, RAM port, UART handshake.
// slave is the dump_ctrl side, master the surrounding system.
interface dump_ctrl_if
  import dump_ctrl_pkg::*;
#(
  parameter int LOG2 = CAP_LOG2
);

  logic            dump;
  logic            capture_done;
  logic [LOG2-1:0] waddr_cap;
  logic [7:0]      rdata;
  logic            tx_done;
  logic [LOG2-1:0] raddr;
  logic            re;
  logic [7:0]      tx_data;
  logic            trmt;
  logic            dump_busy;
  logic            dump_done;

  modport slave (
    input  dump,
    input  capture_done,
    input  waddr_cap,
    input  rdata,
    input  tx_done,
    output raddr,
    output re,
    output tx_data,
    output trmt,
    output dump_busy,
    output dump_done
  );

  modport master (
    output dump,
    output capture_done,
    output waddr_cap,
    output rdata,
    output tx_done,
    input  raddr,
    input  re,
    input  tx_data,
    input  trmt,
    input  dump_busy,
    input  dump_done
  );

endinterface

// File: rtl/dump_ctrl_circ_ptr.sv
// Load/increment circular pointer wrapping at ENTRIES-1.
// Depth need not be a power of two; load has priority over increment.
module circ_ptr
  import dump_ctrl_pkg::*;
#(
  parameter int ENTRIES = CAP_ENTRIES,
  parameter int LOG2    = CAP_LOG2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            load,
  input  logic            inc,
  input  logic [LOG2-1:0] load_val,
  output logic [LOG2-1:0] ptr
);

  localparam logic [LOG2-1:0] LAST = LOG2'(ENTRIES - 1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= '0;
    end else if (load) begin
      ptr <= load_val;
    end else if (inc) begin
      ptr <= (ptr == LAST) ? '0 : ptr + LOG2'(1);
    end
  end

endmodule

// File: rtl/dump_ctrl.sv
// Sample RAM readout: streams every entry, oldest first, to the UART.
// All outputs are registered; rdata never reaches an output combinationally.
module dump_ctrl
  import dump_ctrl_pkg::*;
#(
  parameter int ENTRIES = CAP_ENTRIES,
  parameter int LOG2    = CAP_LOG2
) (
  input logic        clk,
  input logic        rst_n,
  dump_ctrl_if.slave bus
);

  localparam logic [LOG2-1:0] LAST = LOG2'(ENTRIES - 1);

  dump_state_t     state;
  dump_state_t     state_d;
  logic [LOG2-1:0] cnt;
  logic [LOG2-1:0] cnt_d;
  logic [LOG2-1:0] raddr;
  logic            rvalid;
  logic            re_q;
  logic            re_d;
  logic            trmt_q;
  logic            trmt_d;
  logic            busy_q;
  logic            busy_d;
  logic            done_q;
  logic            done_d;
  logic [7:0]      txd_q;
  logic [7:0]      txd_d;
  logic            ld;
  logic            inc;

  circ_ptr #(
    .ENTRIES (ENTRIES),
    .LOG2    (LOG2)
  ) u_rptr (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (ld),
    .inc      (inc),
    .load_val (bus.waddr_cap),
    .ptr      (raddr)
  );

  // LATCH waits for rvalid, which marks the cycle the RAM data is present.
  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    re_d    = 1'b0;
    trmt_d  = 1'b0;
    done_d  = 1'b0;
    busy_d  = busy_q;
    txd_d   = txd_q;
    ld      = 1'b0;
    inc     = 1'b0;
    unique case (state)
      IDLE: begin
        if (bus.dump && bus.capture_done) begin
          ld      = 1'b1;
          cnt_d   = '0;
          busy_d  = 1'b1;
          state_d = RD;
        end
      end
      RD: begin
        re_d    = 1'b1;
        state_d = LATCH;
      end
      LATCH: begin
        if (rvalid) begin
          txd_d   = bus.rdata;
          trmt_d  = 1'b1;
          state_d = WAIT_TX;
        end
      end
      WAIT_TX: begin
        if (bus.tx_done) begin
          if (cnt == LAST) begin
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = IDLE;
          end else begin
            cnt_d   = cnt + LOG2'(1);
            inc     = 1'b1;
            state_d = RD;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      cnt    <= '0;
      rvalid <= 1'b0;
      re_q   <= 1'b0;
      trmt_q <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      txd_q  <= '0;
    end else begin
      state  <= state_d;
      cnt    <= cnt_d;
      rvalid <= re_q;
      re_q   <= re_d;
      trmt_q <= trmt_d;
      busy_q <= busy_d;
      done_q <= done_d;
      txd_q  <= txd_d;
    end
  end

  assign bus.raddr     = raddr;
  assign bus.re        = re_q;
  assign bus.tx_data   = txd_q;
  assign bus.trmt      = trmt_q;
  assign bus.dump_busy = busy_q;
  assign bus.dump_done = done_q;

endmodule

// File: tb/tb_dump_ctrl.sv
// Directed bench for dump_ctrl: 8-entry and 384-entry instances,
// behavioral sync RAM (mem[i] = i + 0x10) and a 4-cycle UART model.
module tb_dump_ctrl;
  import dump_ctrl_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  dump_ctrl_if #(.LOG2(3)) b8 ();
  dump_ctrl_if #(.LOG2(9)) b3 ();

  dump_ctrl #(.ENTRIES(8), .LOG2(3)) u8 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (b8.slave)
  );

  dump_ctrl #(.ENTRIES(384), .LOG2(9)) u384 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (b3.slave)
  );

  logic [7:0] mem8 [8];
  logic [7:0] mem3 [384];

  initial begin
    for (int i = 0; i < 8; i++) mem8[i] = 8'(i + 16);
    for (int i = 0; i < 384; i++) mem3[i] = 8'(i + 16);
  end

  always @(posedge clk) begin
    if (b8.re) b8.rdata <= mem8[b8.raddr];
    if (b3.re) b3.rdata <= mem3[b3.raddr];
  end

  logic [3:0] sr8;
  logic [3:0] sr3;
  logic       stray8;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr8 <= '0;
      sr3 <= '0;
    end else begin
      sr8 <= {sr8[2:0], b8.trmt};
      sr3 <= {sr3[2:0], b3.trmt};
    end
  end

  assign b8.tx_done = sr8[3] | stray8;
  assign b3.tx_done = sr3[3];

  logic [7:0] tx8 [$];
  logic [2:0] ra8 [$];
  logic [7:0] tx3 [$];
  logic [8:0] ra3 [$];
  int dn8 = 0;
  int bd8 = 0;
  int hi3 = 0;

  always @(negedge clk) begin
    if (b8.trmt) tx8.push_back(b8.tx_data);
    if (b8.re) ra8.push_back(b8.raddr);
    if (b8.dump_done) dn8++;
    if (b8.dump_done && b8.dump_busy) bd8++;
    if (b3.trmt) tx3.push_back(b3.tx_data);
    if (b3.re) ra3.push_back(b3.raddr);
    if (b3.raddr >= 9'd384) hi3++;
  end

  int pass_n = 0;
  int tot_n = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse8();
    @(negedge clk);
    b8.dump = 1'b1;
    @(posedge clk);
    #1;
    b8.dump = 1'b0;
  endtask

  // Returns at the negedge of the dump_done cycle, or flags a timeout.
  task automatic wait_done8(input int budget, input string nm);
    bit seen;
    seen = 1'b0;
    for (int c = 0; c < budget; c++) begin
      @(negedge clk);
      if (b8.dump_done) begin
        seen = 1'b1;
        break;
      end
    end
    tot_n++;
    if (!seen) $display("FAIL %s_timeout: no dump_done in %0d cycles", nm, budget);
    else pass_n++;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    b8.dump = 1'b0; b8.capture_done = 1'b0; b8.waddr_cap = '0;
    b3.dump = 1'b0; b3.capture_done = 1'b0; b3.waddr_cap = '0;
    stray8 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    tot_n++; if (b8.re !== 1'b0) $display("FAIL rst_re: got %b want 0", b8.re); else pass_n++;
    tot_n++; if (b8.trmt !== 1'b0) $display("FAIL rst_trmt: got %b want 0", b8.trmt); else pass_n++;
    tot_n++; if (b8.tx_data !== 8'h00) $display("FAIL rst_txd: got %h want 00", b8.tx_data); else pass_n++;
    tot_n++; if (b8.dump_busy !== 1'b0) $display("FAIL rst_busy: got %b want 0", b8.dump_busy); else pass_n++;
    tot_n++; if (b8.dump_done !== 1'b0) $display("FAIL rst_done: got %b want 0", b8.dump_done); else pass_n++;
    tot_n++; if (b8.raddr !== 3'd0) $display("FAIL rst_raddr: got %0d want 0", b8.raddr); else pass_n++;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_first_byte();
    int s;
    int d;
    s = tx8.size();
    d = dn8;
    b8.waddr_cap = 3'd0;
    b8.capture_done = 1'b1;
    pulse8();
    tot_n++; if (b8.dump_busy !== 1'b1) $display("FAIL t1_busy: got %b want 1", b8.dump_busy); else pass_n++;
    tot_n++; if (b8.re !== 1'b0) $display("FAIL t1_re_k: got %b want 0", b8.re); else pass_n++;
    tick();
    tot_n++; if (b8.re !== 1'b1) $display("FAIL t1_re_k1: got %b want 1", b8.re); else pass_n++;
    tick();
    tot_n++; if (b8.trmt !== 1'b0) $display("FAIL t1_trmt_k2: got %b want 0", b8.trmt); else pass_n++;
    tick();
    tot_n++; if (b8.trmt !== 1'b1) $display("FAIL t1_trmt_k3: got %b want 1", b8.trmt); else pass_n++;
    tot_n++; if (b8.tx_data !== 8'h10) $display("FAIL t1_txd0: got %h want 10", b8.tx_data); else pass_n++;
    tick();
    tot_n++; if (b8.trmt !== 1'b0) $display("FAIL t1_trmt_k4: got %b want 0", b8.trmt); else pass_n++;
    wait_done8(300, "t1");
    tot_n++; if (b8.dump_busy !== 1'b0) $display("FAIL t1_busy_end: got %b want 0", b8.dump_busy); else pass_n++;
    repeat (10) tick();
    tot_n++; if (tx8.size() - s !== 8) $display("FAIL t1_count: got %0d want 8", tx8.size() - s); else pass_n++;
    for (int i = 0; i < 8; i++) begin
      logic [7:0] e;
      e = 8'(16 + i);
      tot_n++; if (tx8[s+i] !== e) $display("FAIL t1_byte%0d: got %h want %h", i, tx8[s+i], e); else pass_n++;
    end
    tot_n++; if (dn8 - d !== 1) $display("FAIL t1_done_cnt: got %0d want 1", dn8 - d); else pass_n++;
    tot_n++; if (bd8 !== 0) $display("FAIL t1_busy_with_done: got %0d want 0", bd8); else pass_n++;
  endtask

  task automatic test_wrap();
    int st;
    int sa;
    st = tx8.size();
    sa = ra8.size();
    b8.waddr_cap = 3'd5;
    b8.capture_done = 1'b1;
    pulse8();
    wait_done8(300, "t2");
    repeat (6) tick();
    tot_n++; if (tx8.size() - st !== 8) $display("FAIL t2_count: got %0d want 8", tx8.size() - st); else pass_n++;
    for (int i = 0; i < 8; i++) begin
      logic [2:0] ea;
      logic [7:0] eb;
      ea = 3'((5 + i) % 8);
      eb = 8'(16 + (5 + i) % 8);
      tot_n++; if (ra8[sa+i] !== ea) $display("FAIL t2_raddr%0d: got %0d want %0d", i, ra8[sa+i], ea); else pass_n++;
      tot_n++; if (tx8[st+i] !== eb) $display("FAIL t2_byte%0d: got %h want %h", i, tx8[st+i], eb); else pass_n++;
    end
  endtask

  task automatic test_full_depth();
    int st;
    int sa;
    int bad_b;
    int bad_a;
    bit seen;
    st = tx3.size();
    sa = ra3.size();
    b3.waddr_cap = 9'd383;
    b3.capture_done = 1'b1;
    @(negedge clk);
    b3.dump = 1'b1;
    @(posedge clk);
    #1;
    b3.dump = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 6000; c++) begin
      @(negedge clk);
      if (b3.dump_done) begin
        seen = 1'b1;
        break;
      end
    end
    tot_n++; if (!seen) $display("FAIL t3_timeout: no dump_done in 6000 cycles"); else pass_n++;
    repeat (10) tick();
    tot_n++; if (tx3.size() - st !== 384) $display("FAIL t3_count: got %0d want 384", tx3.size() - st); else pass_n++;
    tot_n++; if (ra3[sa] !== 9'd383) $display("FAIL t3_raddr0: got %0d want 383", ra3[sa]); else pass_n++;
    tot_n++; if (ra3[sa+1] !== 9'd0) $display("FAIL t3_raddr1: got %0d want 0", ra3[sa+1]); else pass_n++;
    tot_n++; if (hi3 !== 0) $display("FAIL t3_raddr_range: got %0d cycles >= 384 want 0", hi3); else pass_n++;
    bad_b = 0;
    bad_a = 0;
    for (int i = 0; i < 384; i++) begin
      if (tx3[st+i] !== 8'(16 + (383 + i) % 384)) bad_b++;
      if (ra3[sa+i] !== 9'((383 + i) % 384)) bad_a++;
    end
    tot_n++; if (bad_b !== 0) $display("FAIL t3_bytes: got %0d wrong want 0", bad_b); else pass_n++;
    tot_n++; if (bad_a !== 0) $display("FAIL t3_addrs: got %0d wrong want 0", bad_a); else pass_n++;
  endtask

  task automatic test_no_capture();
    int st;
    int sa;
    int busy_seen;
    st = tx8.size();
    sa = ra8.size();
    busy_seen = 0;
    b8.capture_done = 1'b0;
    b8.waddr_cap = 3'd1;
    pulse8();
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (b8.dump_busy !== 1'b0) busy_seen++;
    end
    tot_n++; if (busy_seen !== 0) $display("FAIL t4_busy: got %0d busy cycles want 0", busy_seen); else pass_n++;
    tot_n++; if (ra8.size() - sa !== 0) $display("FAIL t4_re: got %0d reads want 0", ra8.size() - sa); else pass_n++;
    tot_n++; if (tx8.size() - st !== 0) $display("FAIL t4_trmt: got %0d strobes want 0", tx8.size() - st); else pass_n++;
    b8.capture_done = 1'b1;
  endtask

  // Stray dump/tx_done injected in every RD and first LATCH cycle.
  task automatic test_stray();
    int st;
    int d;
    bit prev;
    bit inj;
    bit seen;
    st = tx8.size();
    d = dn8;
    b8.waddr_cap = 3'd0;
    b8.capture_done = 1'b1;
    pulse8();
    b8.dump = 1'b1;
    stray8 = 1'b1;
    tick();
    b8.dump = 1'b0;
    stray8 = 1'b0;
    prev = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      if (b8.dump_done) begin
        seen = 1'b1;
        break;
      end
      inj = b8.dump_busy && (b8.re || prev);
      prev = sr8[3];
      b8.dump = inj;
      stray8 = inj;
      if (c == 20) b8.capture_done = 1'b0;
    end
    b8.dump = 1'b0;
    stray8 = 1'b0;
    tot_n++; if (!seen) $display("FAIL t5_timeout: no dump_done in 400 cycles"); else pass_n++;
    repeat (12) tick();
    b8.capture_done = 1'b1;
    tot_n++; if (tx8.size() - st !== 8) $display("FAIL t5_count: got %0d want 8", tx8.size() - st); else pass_n++;
    for (int i = 0; i < 8; i++) begin
      logic [7:0] e;
      e = 8'(16 + i);
      tot_n++; if (tx8[st+i] !== e) $display("FAIL t5_byte%0d: got %h want %h", i, tx8[st+i], e); else pass_n++;
    end
    tot_n++; if (dn8 - d !== 1) $display("FAIL t5_done_cnt: got %0d want 1", dn8 - d); else pass_n++;
    tot_n++; if (b8.dump_busy !== 1'b0) $display("FAIL t5_busy_end: got %b want 0", b8.dump_busy); else pass_n++;
  endtask

  task automatic test_reset_mid();
    int st;
    bit seen;
    st = tx8.size();
    b8.waddr_cap = 3'd0;
    b8.capture_done = 1'b1;
    pulse8();
    seen = 1'b0;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (tx8.size() - st >= 3) begin
        seen = 1'b1;
        break;
      end
    end
    tot_n++; if (!seen) $display("FAIL t6_third_byte: only %0d bytes in 200 cycles", tx8.size() - st); else pass_n++;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    tot_n++; if (b8.dump_busy !== 1'b0) $display("FAIL t6_busy: got %b want 0", b8.dump_busy); else pass_n++;
    tot_n++; if (b8.re !== 1'b0) $display("FAIL t6_re: got %b want 0", b8.re); else pass_n++;
    tot_n++; if (b8.trmt !== 1'b0) $display("FAIL t6_trmt: got %b want 0", b8.trmt); else pass_n++;
    tot_n++; if (b8.tx_data !== 8'h00) $display("FAIL t6_txd: got %h want 00", b8.tx_data); else pass_n++;
    tot_n++; if (b8.dump_done !== 1'b0) $display("FAIL t6_done: got %b want 0", b8.dump_done); else pass_n++;
    tot_n++; if (b8.raddr !== 3'd0) $display("FAIL t6_raddr: got %0d want 0", b8.raddr); else pass_n++;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) tick();
    st = tx8.size();
    b8.waddr_cap = 3'd2;
    pulse8();
    wait_done8(300, "t6");
    repeat (6) tick();
    tot_n++; if (tx8.size() - st !== 8) $display("FAIL t6_count: got %0d want 8", tx8.size() - st); else pass_n++;
    for (int i = 0; i < 8; i++) begin
      logic [7:0] e;
      e = 8'(16 + (2 + i) % 8);
      tot_n++; if (tx8[st+i] !== e) $display("FAIL t6_byte%0d: got %h want %h", i, tx8[st+i], e); else pass_n++;
    end
  endtask

  task automatic test_back_to_back();
    b8.waddr_cap = 3'd3;
    b8.capture_done = 1'b1;
    pulse8();
    wait_done8(300, "t7a");
    tot_n++; if (b8.dump_busy !== 1'b0) $display("FAIL t7_busy_fall: got %b want 0", b8.dump_busy); else pass_n++;
    b8.waddr_cap = 3'd6;
    b8.dump = 1'b1;
    tick();
    b8.dump = 1'b0;
    tot_n++; if (b8.dump_busy !== 1'b1) $display("FAIL t7_accept: got %b want 1", b8.dump_busy); else pass_n++;
    repeat (3) tick();
    tot_n++; if (b8.trmt !== 1'b1) $display("FAIL t7_trmt: got %b want 1", b8.trmt); else pass_n++;
    tot_n++; if (b8.tx_data !== 8'h16) $display("FAIL t7_txd: got %h want 16", b8.tx_data); else pass_n++;
    wait_done8(300, "t7b");
    repeat (4) tick();
  endtask

  initial begin
    test_reset();
    test_first_byte();
    test_wrap();
    test_full_depth();
    test_no_capture();
    test_stray();
    test_reset_mid();
    test_back_to_back();
    $display("%0d/%0d checks passed", pass_n, tot_n);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
